// File: rtl/nibble_seq_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encodings, the slice
// width and an index-width helper.
package nibble_seq_pkg;

  // FSM state encodings (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of the shared adder slice
  localparam int NIBBLE_W = 4;

  // Ceiling log2, used to size the nibble index register
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nibble_add_seq_add4_slice.sv
// add4_slice: combinational 4-bit ripple-carry adder. Each full adder takes
// the carry of the stage below it, so the carry ripples bit by bit.
module add4_slice
  import nibble_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] c_s;

  assign c_s[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]       = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i + 1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign co = c_s[NIBBLE_W];

endmodule

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: adds two W-bit operands one nibble per clock, LSB first,
// through a single shared 4-bit slice with a registered carry between nibbles.
// Optional feature: define NIBBLE_SEQ_SUB_EN to add a 'sub' input that turns
// the operation into a - b (computed as a + ~b + 1).
module nibble_add_seq
  import nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [4*NIBBLES-1:0]      a,
  input  logic [4*NIBBLES-1:0]      b,
  input  logic                      cin,
`ifdef NIBBLE_SEQ_SUB_EN
  input  logic                      sub,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [4*NIBBLES-1:0]      sum,
  output logic                      cout
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, done_q;

  // Bit offset of the nibble currently being processed
  logic [IDX_W+1:0]    nib_lsb_s;
  logic [NIBBLE_W-1:0] slice_a_s, slice_b_s, slice_s_s;
  logic                slice_co_s;

  // Operand B and carry-in as captured at accept; subtract inverts B and forces carry
  logic [W-1:0]        b_cap_s;
  logic                cin_cap_s;

  assign nib_lsb_s = {idx_q, 2'b00};
  assign slice_a_s = a_q[nib_lsb_s +: NIBBLE_W];
  assign slice_b_s = b_q[nib_lsb_s +: NIBBLE_W];

  add4_slice u_slice (
    .a  (slice_a_s),
    .b  (slice_b_s),
    .ci (carry_q),
    .s  (slice_s_s),
    .co (slice_co_s)
  );

`ifdef NIBBLE_SEQ_SUB_EN
  // Capture-time operand conditioning for add or subtract
  always_comb begin
    if (sub) begin
      b_cap_s   = ~b;
      cin_cap_s = 1'b1;
    end else begin
      b_cap_s   = b;
      cin_cap_s = cin;
    end
  end
`else
  assign b_cap_s   = b;
  assign cin_cap_s = cin;
`endif

  // Next-state logic: accept in IDLE, one nibble per cycle in RUN, one-cycle DONE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_cap_s;
          carry_d = cin_cap_s;
          sum_d   = {W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[nib_lsb_s +: NIBBLE_W] = slice_s_s;
        carry_d = slice_co_s;
        if (idx_q == IDX_LAST) begin
          cout_d  = slice_co_s;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; outputs registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= {IDX_W{1'b0}};
      carry_q <= 1'b0;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      sum_q   <= {W{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
